// File: rtl/alpha_display_mux_if.sv
// Character-write channel for alpha_display_mux: valid/ready handshake plus
// the synchronous buffer clear that shares the write path.
interface alpha_display_mux_if;
   logic       wr_valid;
   logic [4:0] wr_char;
   logic       wr_ready;
   logic       clr;

   modport master (output wr_valid, output wr_char, output clr, input  wr_ready);
   modport slave  (input  wr_valid, input  wr_char, input  clr, output wr_ready);
endinterface

// File: rtl/alpha_display_mux.sv
// Multiplexed seven-segment letter display: shift-in character buffer,
// digit scan with registered active-low outputs and optional whole-display blink.
module alpha_display_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alpha_display_mux_if.slave    wr,
   input  logic                  blink,
   input  logic [NUM_DIGITS-1:0] dp,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] an
);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [NUM_DIGITS-1:0]      vld_q;
   logic [NUM_DIGITS-1:0][4:0] code_q;
   logic [RW-1:0]              ref_q;
   logic [IW-1:0]              idx_q;
   logic [FW-1:0]              frame_q;
   logic                       phase_q;
   logic                       rdy_q;

   logic                       term, last_digit, frame_wrap, dark;
   logic [7:0]                 seg_nxt;
   logic [NUM_DIGITS-1:0]      an_nxt;

   // Segment patterns a..g for A..Z; the dp bit of each table entry is dropped.
   function automatic logic [6:0] glyph(input logic [4:0] c);
      logic [7:0] g;
      case (c)
         5'd0:  g = 8'h11;  5'd1:  g = 8'hC1;  5'd2:  g = 8'h63;  5'd3:  g = 8'h85;
         5'd4:  g = 8'h61;  5'd5:  g = 8'h71;  5'd6:  g = 8'h09;  5'd7:  g = 8'hD1;
         5'd8:  g = 8'hF3;  5'd9:  g = 8'h87;  5'd10: g = 8'h51;  5'd11: g = 8'hE3;
         5'd12: g = 8'h57;  5'd13: g = 8'h13;  5'd14: g = 8'h03;  5'd15: g = 8'h31;
         5'd16: g = 8'h19;  5'd17: g = 8'hF5;  5'd18: g = 8'h49;  5'd19: g = 8'hE1;
         5'd20: g = 8'h83;  5'd21: g = 8'hAB;  5'd22: g = 8'hA9;  5'd23: g = 8'h91;
         5'd24: g = 8'h89;  5'd25: g = 8'h25;
         default: g = 8'hFF;
      endcase
      return g[7:1];
   endfunction

   assign term       = (ref_q == RW'(REFRESH_DIV - 1));
   assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
   assign frame_wrap = term && last_digit;
   // Dropping BLINK must light the display on the very next edge, so the
   // stored phase is gated rather than waited on.
   assign dark       = blink && phase_q;
   assign wr.wr_ready = rdy_q;

   always_comb begin
      an_nxt  = '1;
      seg_nxt = 8'hFF;
      if (!dark) begin
         an_nxt[idx_q] = 1'b0;
         if (vld_q[idx_q] && (code_q[idx_q] <= 5'd25))
            seg_nxt[7:1] = glyph(code_q[idx_q]);
         seg_nxt[0] = ~dp[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= '0;
         code_q  <= '0;
         ref_q   <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         phase_q <= 1'b0;
         rdy_q   <= 1'b0;
         seg     <= 8'hFF;
         an      <= '1;
      end else begin
         rdy_q <= ~wr.clr;
         if (wr.clr) begin
            vld_q <= '0;
         end else if (wr.wr_valid && rdy_q) begin
            vld_q  <= {vld_q[NUM_DIGITS-2:0], 1'b1};
            code_q <= {code_q[NUM_DIGITS-2:0], wr.wr_char};
         end

         ref_q <= term ? '0 : ref_q + 1'b1;
         if (term)
            idx_q <= last_digit ? '0 : idx_q + 1'b1;

         if (!blink) begin
            frame_q <= '0;
            phase_q <= 1'b0;
         end else if (frame_wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
               frame_q <= '0;
               phase_q <= ~phase_q;
            end else begin
               frame_q <= frame_q + 1'b1;
            end
         end

         seg <= seg_nxt;
         an  <= an_nxt;
      end
   end
endmodule
